// File: rtl/iter_div_fsm_if.sv
// Handshake and result bundle between a controller (master) and the iterative divider (slave).
interface iter_div_fsm_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             signed_en;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, signed_en, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, signed_en, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/iter_div_fsm.sv
// Iterative restoring divider: aligns the divisor under the dividend, then subtracts one bit per cycle.
module iter_div_fsm #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  iter_div_fsm_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ALIGN, SUB, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q;
  logic [WIDTH-1:0] rem_q, dvs_q, mask_q, qacc_q;
  logic [WIDTH-1:0] quo_q, rmd_q;
  logic             negq_q, negr_q, sgn_q;
  logic             busy_q, done_q, dbz_q, ovf_q;

  logic [WIDTH-1:0] abs_n, abs_d, rem_sub, qacc_sub, quo_fix, rmd_fix;
  logic             align_more, rem_ge, ovf_fix;

  always_comb begin
    abs_n = (bus.signed_en && bus.dividend[WIDTH-1]) ? ('0 - bus.dividend) : bus.dividend;
    abs_d = (bus.signed_en && bus.divisor[WIDTH-1])  ? ('0 - bus.divisor)  : bus.divisor;
    // Compare against the doubled divisor with one spare bit so the shift never wraps.
    align_more = ({1'b0, rem_q} >= {dvs_q, 1'b0}) && !mask_q[WIDTH-1];
    rem_ge   = (rem_q >= dvs_q);
    rem_sub  = rem_ge ? (rem_q - dvs_q) : rem_q;
    qacc_sub = rem_ge ? (qacc_q | mask_q) : qacc_q;
    quo_fix  = negq_q ? ('0 - qacc_sub) : qacc_sub;
    rmd_fix  = negr_q ? ('0 - rem_sub) : rem_sub;
    ovf_fix  = sgn_q && !negq_q && (qacc_sub == MSB_ONLY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dvs_q   <= '0;
      mask_q  <= '0;
      qacc_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      sgn_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            sgn_q  <= bus.signed_en;
            negq_q <= bus.signed_en && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            negr_q <= bus.signed_en && bus.dividend[WIDTH-1];
            rem_q  <= abs_n;
            dvs_q  <= abs_d;
            qacc_q <= '0;
            mask_q <= ONE;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              dbz_q   <= 1'b1;
              quo_q   <= '1;
              rmd_q   <= bus.dividend;
              state_q <= DONE;
            end else begin
              dbz_q   <= 1'b0;
              state_q <= ALIGN;
            end
          end
        end
        ALIGN: begin
          if (align_more) begin
            dvs_q  <= dvs_q << 1;
            mask_q <= mask_q << 1;
          end else begin
            state_q <= SUB;
          end
        end
        SUB: begin
          rem_q  <= rem_sub;
          qacc_q <= qacc_sub;
          if (mask_q == ONE) begin
            quo_q   <= quo_fix;
            rmd_q   <= rmd_fix;
            ovf_q   <= ovf_fix;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            dvs_q  <= dvs_q >> 1;
            mask_q <= mask_q >> 1;
          end
        end
        DONE: begin
          // Divide-by-zero arrives here with done still low; give it its one-cycle pulse first.
          if (!done_q) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rmd_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_iter_div_fsm.sv
// Directed bench for iter_div_fsm at WIDTH=8 with hand-computed quotients, remainders and latencies.
module tb_iter_div_fsm;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  iter_div_fsm_if #(.WIDTH(8)) bus ();

  iter_div_fsm #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start one operation, optionally poke a second start (9/3) before edge poke, and check the result.
  task automatic run_op(input string tag, input logic sgn, input logic [7:0] n, input logic [7:0] d,
                        input int poke, input int exp_edge, input logic [7:0] eq, input logic [7:0] er,
                        input logic edbz, input logic eovf);
    int edge_seen;
    int busy_low;
    edge_seen = 41;
    busy_low  = 0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_en = sgn;
    bus.dividend  = n;
    bus.divisor   = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 8'd3;
      end
      @(posedge clk);
      #1 bus.start = 1'b0;
      if (bus.done) begin
        edge_seen = k;
        break;
      end
      if (!bus.busy) busy_low++;
    end
    $display("op %s: n=%0h d=%0h s=%0b -> q=%0h r=%0h dbz=%0b ovf=%0b done_edge=%0d",
             tag, n, d, sgn, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow, edge_seen);
    check_val({tag, ".edge"}, edge_seen, exp_edge);
    check_val({tag, ".q"}, {24'd0, bus.quotient}, {24'd0, eq});
    check_val({tag, ".r"}, {24'd0, bus.remainder}, {24'd0, er});
    check_val({tag, ".dbz"}, {31'd0, bus.div_by_zero}, {31'd0, edbz});
    check_val({tag, ".ovf"}, {31'd0, bus.overflow}, {31'd0, eovf});
    check_val({tag, ".busy_gap"}, busy_low, 0);
    check_val({tag, ".busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    #1 check_val({tag, ".done_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_en = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst.done", {31'd0, bus.done}, 32'd0);
    check_val("rst.q", {24'd0, bus.quotient}, 32'd0);
    check_val("rst.r", {24'd0, bus.remainder}, 32'd0);
    check_val("rst.flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    //      tag        sgn   N      D      poke edge q      r      dbz   ovf
    run_op("u100_7",  1'b0, 8'd100, 8'd7,  0,   8,  8'd14,  8'd2,  1'b0, 1'b0);
    run_op("u255_1",  1'b0, 8'd255, 8'd1,  0,   16, 8'd255, 8'd0,  1'b0, 1'b0);
    run_op("u5_9",    1'b0, 8'd5,   8'd9,  0,   2,  8'd0,   8'd5,  1'b0, 1'b0);
    run_op("u77_0",   1'b0, 8'd77,  8'd0,  0,   1,  8'hFF,  8'd77, 1'b1, 1'b0);
    run_op("u10_3",   1'b0, 8'd10,  8'd3,  0,   4,  8'd3,   8'd1,  1'b0, 1'b0);
    run_op("s77_0",   1'b1, 8'd77,  8'd0,  0,   1,  8'hFF,  8'd77, 1'b1, 1'b0);
    run_op("sm5_0",   1'b1, 8'hFB,  8'd0,  0,   1,  8'hFF,  8'hFB, 1'b1, 1'b0);
    run_op("sm100_7", 1'b1, 8'h9C,  8'h07, 0,   8,  8'hF2,  8'hFE, 1'b0, 1'b0);
    run_op("s100_m7", 1'b1, 8'd100, 8'hF9, 0,   8,  8'hF2,  8'h02, 1'b0, 1'b0);
    run_op("smin_m1", 1'b1, 8'h80,  8'hFF, 0,   16, 8'h80,  8'h00, 1'b0, 1'b1);
    run_op("poke",    1'b0, 8'd100, 8'd7,  3,   8,  8'd14,  8'd2,  1'b0, 1'b0);
    run_op("u9_3",    1'b0, 8'd9,   8'd3,  0,   4,  8'd3,   8'd0,  1'b0, 1'b0);

    // Asynchronous reset in the middle of SUB for 200/3 (a=6, SUB spans edges 8..14).
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_en = 1'b0;
    bus.dividend  = 8'd200;
    bus.divisor   = 8'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    $display("op midrst: busy=%0b done=%0b q=%0h r=%0h dbz=%0b ovf=%0b",
             bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
    check_val("midrst.busy", {31'd0, bus.busy}, 32'd0);
    check_val("midrst.done", {31'd0, bus.done}, 32'd0);
    check_val("midrst.q", {24'd0, bus.quotient}, 32'd0);
    check_val("midrst.r", {24'd0, bus.remainder}, 32'd0);
    check_val("midrst.flags", {30'd0, bus.div_by_zero, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u200_3",  1'b0, 8'd200, 8'd3,  0,   14, 8'd66,  8'd2,  1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
